// File: rtl/core_pkg.sv
// core_pkg: types and constants shared by the fetch stage and the
// pipeline registers that follow it.
//   fetch_state_t      : fetch FSM states
//   OP/F3/F7 _LSB/_MSB : instruction field positions used by decode
//   NOP_INSTR          : canonical no-op (addi x0, x0, 0)
package core_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam int OP_LSB = 0;
    localparam int OP_MSB = 4;
    localparam int F3_LSB = 12;
    localparam int F3_MSB = 14;
    localparam int F7_LSB = 25;
    localparam int F7_MSB = 31;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus.
//   imem_req    master -> slave : request valid
//   imem_addr   master -> slave : byte address of the request
//   imem_ready  slave -> master : memory accepts the request this cycle
//   imem_rvalid slave -> master : response valid, one pulse per accepted request
//   imem_rdata  slave -> master : instruction word
//
// Handshake: a request transfers on a rising edge where imem_req and
// imem_ready are both 1; until then imem_req stays 1 and imem_addr stays
// stable (a branch redirect is the only thing allowed to retarget a waiting
// request). The response has no ready: the master must take imem_rvalid in
// the cycle it is presented, at least one cycle after the accepting edge.
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_id_register.sv
// if_id_register: one pipeline register slot (valid, instr, pc).
//   clk, rst         : clock, asynchronous active-high reset
//   load             : capture instr_in/pc_in as a live entry
//   hold             : keep the current entry bit-exact (downstream stall)
//   flush            : kill the current entry
//   instr_in, pc_in  : entry to capture
//   valid, instr, pc : register contents
// Priority is flush > hold > load. With none of them the slot empties,
// since an entry that is not held has been consumed downstream.
module if_id_register #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_INSTR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            hold,
    input  logic            flush,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= RESET_INSTR;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (!hold) begin
            valid <= load;
            if (load) begin
                instr <= instr_in;
                pc    <= pc_in;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues single-outstanding instruction-memory
// requests and presents the fetched word in the IF/ID register together
// with its decode fields.
//   clk, rst        : clock, asynchronous active-high reset
//   imem            : instruction-memory bus (master side)
//   stall_d         : decode cannot accept; IF/ID holds
//   redirect        : taken-branch pulse, retargets fetch to redirect_pc
//   valid_d, instr_d, pc_d, pc_plus4_d : IF/ID contents
//   op_d, funct3_d, funct7_d           : fields split out of instr_d
//   state_dbg, skid_valid_dbg          : FSM state and skid occupancy
module fetch_stage
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_stage_if.master        imem,
    input  logic                 stall_d,
    input  logic                 redirect,
    input  logic [XLEN-1:0]      redirect_pc,
    output logic                 valid_d,
    output logic [XLEN-1:0]      instr_d,
    output logic [XLEN-1:0]      pc_d,
    output logic [XLEN-1:0]      pc_plus4_d,
    output logic [4:0]           op_d,
    output logic [2:0]           funct3_d,
    output logic [6:0]           funct7_d,
    output fetch_state_t         state_dbg,
    output logic                 skid_valid_dbg
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            drop;
    logic            skid_valid;
    logic [XLEN-1:0] skid_instr;
    logic [XLEN-1:0] skid_pc;

    logic            ifid_free;
    logic            resp_live;
    logic            load_from_mem;
    logic            load_from_skid;
    logic            ifid_load;
    logic [XLEN-1:0] ifid_instr_in;
    logic [XLEN-1:0] ifid_pc_in;

    // Bus outputs come only from registered state, never from an input.
    assign imem.imem_req  = (state == REQ);
    assign imem.imem_addr = pc;

    // A stalled slot only blocks loading while it holds something live.
    assign ifid_free = !valid_d || !stall_d;

    // A response counts only if it belongs to the current path.
    assign resp_live      = (state == WAIT) && imem.imem_rvalid && !drop && !redirect;
    assign load_from_mem  = resp_live && ifid_free;
    assign load_from_skid = (state == HOLD) && !stall_d && !redirect;
    assign ifid_load      = load_from_mem || load_from_skid;
    assign ifid_instr_in  = load_from_skid ? skid_instr : imem.imem_rdata;
    assign ifid_pc_in     = load_from_skid ? skid_pc    : req_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            req_pc     <= RESET_PC;
            drop       <= 1'b0;
            skid_valid <= 1'b0;
            skid_instr <= XLEN'(NOP_INSTR);
            skid_pc    <= '0;
        end else begin
            case (state)
                BOOT: begin
                    if (redirect) pc <= redirect_pc;
                    state <= REQ;
                end
                REQ: begin
                    if (redirect) pc <= redirect_pc;
                    if (imem.imem_ready) begin
                        // The accepted request carries the old pc; if a
                        // redirect lands in the same cycle its answer is stale.
                        req_pc <= pc;
                        drop   <= redirect;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                        if (imem.imem_rvalid) begin
                            drop  <= 1'b0;
                            state <= REQ;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (imem.imem_rvalid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= REQ;
                        end else begin
                            pc <= req_pc + XLEN'(4);
                            if (ifid_free) begin
                                state <= REQ;
                            end else begin
                                skid_valid <= 1'b1;
                                skid_instr <= imem.imem_rdata;
                                skid_pc    <= req_pc;
                                state      <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc         <= redirect_pc;
                        skid_valid <= 1'b0;
                        state      <= REQ;
                    end else if (!stall_d) begin
                        skid_valid <= 1'b0;
                        state      <= REQ;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    if_id_register #(
        .XLEN        (XLEN),
        .RESET_INSTR (XLEN'(NOP_INSTR))
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load     (ifid_load),
        .hold     (stall_d && valid_d),
        .flush    (redirect),
        .instr_in (ifid_instr_in),
        .pc_in    (ifid_pc_in),
        .valid    (valid_d),
        .instr    (instr_d),
        .pc       (pc_d)
    );

    assign pc_plus4_d = pc_d + XLEN'(4);
    assign op_d       = instr_d[OP_MSB:OP_LSB];
    assign funct3_d   = instr_d[F3_MSB:F3_LSB];
    assign funct7_d   = instr_d[F7_MSB:F7_LSB];

    assign state_dbg      = state;
    assign skid_valid_dbg = skid_valid;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the pipelined scalar/vector core: owns the PC, issues single-outstanding requests to instruction memory, and holds the fetched word in the IF/ID pipeline register. It splits out the `op`, `funct3` and `funct7` fields that the decode stage's control unit consumes. It also absorbs decode stalls through a one-entry skid buffer and branch redirects through request tagging.

## Interface

**Parameters**
- `XLEN`, 32: PC and instruction width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_req` out 1: request valid; address is held stable until accepted.
- `imem_addr` out XLEN: byte address of the request.
- `imem_ready` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: response data is valid, one pulse per accepted request.
- `imem_rdata` in XLEN: instruction word.
- `stall_d` in 1: decode cannot accept; IF/ID holds.
- `redirect` in 1: branch taken; single-cycle pulse.
- `redirect_pc` in XLEN: branch target.
- `valid_d` out 1: IF/ID holds a live instruction.
- `instr_d` out XLEN: IF/ID instruction.
- `pc_d` out XLEN: PC of `instr_d`.
- `pc_plus4_d` out XLEN: `pc_d + 4`.
- `op_d` out 5: `instr_d[4:0]`.
- `funct3_d` out 3: `instr_d[14:12]`.
- `funct7_d` out 7: `instr_d[31:25]`.

## Operation

**FSM states**
- **BOOT**
  - Reset state; `imem_req`=0.
  - Goes to REQ on the first clock after `rst` drops.
- **REQ**
  - `imem_req`=1, `imem_addr`=pc.
  - On `imem_ready`: goes to WAIT and latches `req_pc`=pc.
- **WAIT**
  - Waits for `imem_rvalid`.
  - If the `drop` flag is set: discards the response, clears `drop`, goes to REQ.
  - Else, if IF/ID can load (`!valid_d || !stall_d`): loads `{imem_rdata, req_pc}`, sets pc=`req_pc`+4, goes to REQ.
  - Else: writes the skid buffer, sets pc=`req_pc`+4, goes to HOLD.
- **HOLD**
  - `imem_req`=0.
  - When `stall_d`=0: moves skid into IF/ID, goes to REQ.

**Redirect** (`redirect`=1) has priority over stall and over a response in the same cycle.
- pc ← `redirect_pc`; `valid_d` ← 0 next cycle (flush); skid is invalidated.
- In WAIT with no `rvalid` this cycle: set `drop`, stay in WAIT.
- In REQ with `imem_ready`=1 this cycle: the request goes out with the old pc; set `drop`, go to WAIT.
- In WAIT with `rvalid` this cycle: discard the response, go to REQ.
- In HOLD: go to REQ.
- In BOOT: pc takes `redirect_pc` and the state still goes to REQ.

**Other rules**
- `stall_d` with `valid_d`=1 holds every IF/ID output bit-exact.
- `stall_d` with `valid_d`=0 does not block loading.
- PC arithmetic is modulo 2^XLEN; pc wraps from `32'hFFFF_FFFC` to 0.
- At most one outstanding request; no request is issued in WAIT or HOLD.

**Reset values**
- `imem_req`=0, `imem_addr`=`RESET_PC`.
- `valid_d`=0; `instr_d`=`NOP_INSTR`.
- `pc_d`=0, `pc_plus4_d`=4.
- Field outputs are derived from `NOP_INSTR`.
- `drop`=0, skid invalid.
- Reset mid-transaction abandons the outstanding request. A later stray `rvalid` in BOOT/REQ is ignored.

## Timing

- Request accepted in cycle N, `rvalid` in N+k (k≥1): `valid_d`=1 from N+k+1.
- Next request is presented in N+k+1.
- Peak throughput: one instruction per 2 cycles when k=1.
- Redirect in cycle R: `valid_d`=0 in R+1.
  - If no request was outstanding: first request to the target is in R+1.
  - If a request was outstanding: first request to the target follows the dropped response.
- Field outputs are combinational from `instr_d`, with zero added latency.
- `imem_addr` and `imem_req` are driven from registered state and pc only; no combinational path from any input.

## Structure

**Shared package `core_pkg`**
- `fetch_state_t` enum {BOOT, REQ, WAIT, HOLD}.
- Field-position localparams: `OP_LSB`/`OP_MSB`, `F3_LSB`/`F3_MSB`, `F7_LSB`/`F7_MSB`.
- `NOP_INSTR`.

**Sub-module `if_id_register`**
- Contents: `valid`/`instr`/`pc` flops.
- Inputs: load, hold (stall), flush (redirect).
- Flush beats hold; hold beats load.
- Reused by the later ID/EX register pattern.

## Test plan

- **Reset release:** `imem_ready`=1 and `rvalid` one cycle after each accept.
  - `imem_addr` sequence is 0, 4, 8.
  - `valid_d` first rises 3 cycles after `rst` falls, with `pc_d`=0.
- **Field split:** `imem_rdata`=32'hFE00_7093 → `op_d`=5'h13, `funct3_d`=3'b111, `funct7_d`=7'h7F.
- **Stall into skid:** `stall_d`=1 while `valid_d`=1 and `rvalid` arrives with 32'h11.
  - IF/ID is unchanged; FSM enters HOLD and `imem_req` stays 0.
  - One cycle after `stall_d` drops, `instr_d`=32'h11 and a request to `req_pc`+4 issues.
- **Redirect while in WAIT:** `redirect`=1 with `redirect_pc`=32'h100.
  - The late response is discarded and `valid_d`=0 the next cycle.
  - The next request has `imem_addr`=32'h100; `pc_d`=32'h100 when it lands.
- **Simultaneous redirect and stall:** `redirect`=1, `stall_d`=1, skid full → `valid_d`=0, skid empty, next request to the target.
- **Wrap-around and async reset:** pc at 32'hFFFF_FFFC fetches, then `imem_addr`=0.
  - `rst` asserted mid-WAIT → `imem_req`=0 and `valid_d`=0 immediately, without a clock edge.
